ysyx_23060203_csu: RTL

YSYX_23060203_CSU -- requirements
Module: ysyx_23060203_CSU

---
 rtl/ysyx_23060203_csu.sv | 90 +++++++++
 1 files changed

// File: rtl/ysyx_23060203_csu.sv
// Control-status unit: accepts a writeback flush, sequences TLB then icache invalidation, then offers the redirect PC.
// pipe_flush is same-cycle; busy holds the IFU until the redirect handshake (redirect_valid & redirect_ready) completes.
module ysyx_23060203_csu (
  input  logic        clock,
  input  logic        reset,
  input  logic        cs_flush,
  input  logic [31:0] cs_dnpc,
  input  logic        flush_icache,
  input  logic        flush_tlb,
  output logic        pipe_flush,
  output logic        busy,
  output logic        tlb_flush_req,
  input  logic        tlb_flush_ack,
  output logic        ic_flush_req,
  input  logic        ic_flush_ack,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TLB   = 2'd1,
    IC    = 2'd2,
    REDIR = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] dnpc_q, dnpc_d;
  logic        icache_q, icache_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        accept;

  // The TLB flag only steers the IDLE exit, so only the icache flag needs to survive past accept.
  assign accept = (state_q == IDLE) && cs_flush;

  always_comb begin
    state_d     = state_q;
    dnpc_d      = dnpc_q;
    icache_d    = icache_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      IDLE: begin
        if (cs_flush) begin
          dnpc_d      = cs_dnpc;
          icache_d    = flush_icache;
          flush_cnt_d = flush_cnt_q + 32'd1;
          if (flush_tlb)         state_d = TLB;
          else if (flush_icache) state_d = IC;
          else                   state_d = REDIR;
        end
      end
      TLB: begin
        if (tlb_flush_ack) state_d = icache_q ? IC : REDIR;
      end
      IC: begin
        if (ic_flush_ack) state_d = REDIR;
      end
      REDIR: begin
        if (redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      dnpc_q      <= 32'd0;
      icache_q    <= 1'b0;
      flush_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      dnpc_q      <= dnpc_d;
      icache_q    <= icache_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Gated by reset so every output is low while reset is held, even with cs_flush high.
  assign pipe_flush     = reset && accept;
  assign busy           = (state_q != IDLE);
  assign tlb_flush_req  = (state_q == TLB);
  assign ic_flush_req   = (state_q == IC);
  assign redirect_valid = (state_q == REDIR);
  assign redirect_pc    = dnpc_q;
  assign flush_cnt      = flush_cnt_q;

endmodule
